// File: rtl/kgp_div_pkg.sv
// Shared types and constants for the 32-bit restoring divider.
// Holds the FSM state encoding plus width/step constants and a negate helper.
package kgp_div_pkg;

  localparam int DIV_W     = 32;
  localparam int CNT_W     = 6;
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [DIV_W-1:0] cond_neg(
    input logic [DIV_W-1:0] v,
    input logic             neg
  );
    return neg ? (~v + DIV_W'(1)) : v;
  endfunction

endpackage

// File: rtl/cla_32_bit.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
// Group carries ripple between groups; bit carries inside a group are flat.
module cla_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Per-group lookahead: internal carries and group carry-out from group cin
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int gi = 0; gi < 8; gi++) begin
      int  k;
      logic gg;
      logic gp;
      k = gi * 4;
      c[k+1] = g[k]
             | (p[k] & c[k]);
      c[k+2] = g[k+1]
             | (p[k+1] & g[k])
             | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2]
             | (p[k+2] & g[k+1])
             | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      gg = g[k+3]
         | (p[k+3] & g[k+2])
         | (p[k+3] & p[k+2] & g[k+1])
         | (p[k+3] & p[k+2] & p[k+1] & g[k]);
      gp = p[k+3] & p[k+2] & p[k+1] & p[k];
      c[k+4] = gg | (gp & c[k]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/restoring_div_32_bit.sv
// 32-bit restoring divider, one quotient bit per cycle over 32 RUN cycles.
// Define DIV_SIGNED_EN to add the is_signed input for two's-complement division.
module restoring_div_32_bit
  import kgp_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_e       state;
  div_state_e       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] dvd;
  logic [DIV_W-1:0] dvs;
  logic [DIV_W-1:0] dvd_org;
  logic [DIV_W-1:0] prem;

  logic [DIV_W:0]   rem_sh;
  logic [DIV_W-1:0] diff;
  logic             cout;
  logic             borrow;
  logic [DIV_W-1:0] prem_nx;
  logic [DIV_W-1:0] dvd_nx;

  logic             accept;
  logic             step;
  logic             zero_dvs;
  logic             last_step;

  logic [DIV_W-1:0] a_mag;
  logic [DIV_W-1:0] b_mag;
  logic [DIV_W-1:0] q_fix;
  logic [DIV_W-1:0] r_fix;

`ifdef DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;
  logic q_neg_in;
  logic r_neg_in;
`endif

  assign accept    = (state == IDLE) & start;
  assign zero_dvs  = (dvs == '0);
  assign step      = (state == RUN) & ~zero_dvs;
  assign last_step = (cnt == CNT_W'(DIV_STEPS - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Operand magnitudes and sign bookkeeping at capture time
`ifdef DIV_SIGNED_EN
  always_comb begin
    q_neg_in = is_signed & (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
    r_neg_in = is_signed & dividend[DIV_W-1];
    a_mag    = cond_neg(dividend, is_signed & dividend[DIV_W-1]);
    b_mag    = cond_neg(divisor, is_signed & divisor[DIV_W-1]);
  end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
  end
`endif

  // One restoring step: shift, trial subtract, keep or restore
  always_comb begin
    rem_sh  = {prem, dvd[DIV_W-1]};
    borrow  = ~cout & ~rem_sh[DIV_W];
    prem_nx = borrow ? rem_sh[DIV_W-1:0] : diff;
    dvd_nx  = {dvd[DIV_W-2:0], ~borrow};
  end

  cla_32_bit u_cla (
    .a    (rem_sh[DIV_W-1:0]),
    .b    (~dvs),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  // Sign correction of the final step result
`ifdef DIV_SIGNED_EN
  always_comb begin
    q_fix = cond_neg(dvd_nx, q_neg);
    r_fix = cond_neg(prem_nx, r_neg);
  end
`else
  always_comb begin
    q_fix = dvd_nx;
    r_fix = prem_nx;
  end
`endif

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (zero_dvs || last_step) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Working registers: capture on accept, shift on each RUN step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      dvd_org <= '0;
      prem    <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          cnt     <= '0;
          dvd     <= a_mag;
          dvs     <= b_mag;
          dvd_org <= dividend;
          prem    <= '0;
        end
        step: begin
          cnt  <= cnt + CNT_W'(1);
          dvd  <= dvd_nx;
          prem <= prem_nx;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_SIGNED_EN
  // Result sign flags latched with the operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      q_neg <= q_neg_in;
      r_neg <= r_neg_in;
    end
  end
`endif

  // Visible results change only when entering DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: div_by_zero <= 1'b0;
        (state == RUN) && zero_dvs: begin
          quotient    <= '1;
          remainder   <= dvd_org;
          div_by_zero <= 1'b1;
        end
        step && last_step: begin
          quotient  <= q_fix;
          remainder <= r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
